// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM capture block.
// Holds the common counter width, the capture state encoding and the default
// stuck-input timeout.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 28;

  localparam logic [PWM_WIDTH-1:0] DEFAULT_TIMEOUT_CYCLES = 28'hFFFFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } capture_state_t;

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_capture_sync: input conditioning for pwm_capture.
// Brings the asynchronous PWM pin into the CLK domain with two flops, optionally
// debounces it, and produces the conditioned level s plus a one-cycle rise pulse.
// Build option: define PWM_CAPTURE_FILTER_EN to insert the glitch filter, which
// only lets s change after FILTER_LEN consecutive identical synchronized samples.
module pwm_capture_sync #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic PWM_IN,
  output logic s,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic s_prev;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= PWM_IN;
      sync_2 <= sync_1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_LEN + 1);

  logic [FCW-1:0] filt_cnt;
  logic           s_filt;

  // Glitch filter: count consecutive samples that disagree with the current
  // level and only flip once FILTER_LEN of them have been seen in a row, so
  // both edges are delayed by the same amount.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      filt_cnt <= '0;
      s_filt   <= 1'b0;
    end else if (sync_2 == s_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
      filt_cnt <= '0;
      s_filt   <= sync_2;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign s = s_filt;
`else
  logic unused_filter_len;

  assign unused_filter_len = (FILTER_LEN != 0);
  assign s = sync_2;
`endif

  // Delayed copy of the conditioned level for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s_prev <= 1'b0;
    end else begin
      s_prev <= s;
    end
  end

  assign rise = s & ~s_prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an incoming PWM waveform in
// CLK cycles and flags stuck-high / stuck-low inputs through a timeout.
// Build option: define PWM_CAPTURE_FILTER_EN to add the input glitch filter
// inside pwm_capture_sync (adds FILTER_LEN cycles of latency).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned      WIDTH          = PWM_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = WIDTH'(DEFAULT_TIMEOUT_CYCLES),
  parameter int unsigned      FILTER_LEN     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [WIDTH-1:0] PERIOD,
  output logic [WIDTH-1:0] DUTY,
  output logic             VALID,
  output logic             TIMEOUT,
  output logic             LEVEL
);

  logic s;
  logic rise;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] hcnt;

  capture_state_t   state_q;
  capture_state_t   state_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_d;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH-1:0] duty_d;
  logic             valid_q;
  logic             valid_d;

  pwm_capture_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sync (
    .CLK   (CLK),
    .RST   (RST),
    .PWM_IN(PWM_IN),
    .s     (s),
    .rise  (rise)
  );

  // Cycle counter since the last rise (saturating at the timeout) and high-time
  // counter that only advances while the conditioned input is high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      if (rise) begin
        cnt <= WIDTH'(1);
      end else if (cnt != TIMEOUT_CYCLES) begin
        cnt <= cnt + WIDTH'(1);
      end

      if (rise) begin
        hcnt <= WIDTH'(1);
      end else if (s) begin
        hcnt <= hcnt + WIDTH'(1);
      end
    end
  end

  // State and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic: a rise in MEAS closes a period and publishes it; running
  // out of cycles in MEAS declares the input stuck and clears the results. A rise
  // out of IDLE or STUCK only starts a fresh period, since the one ending there
  // is partial. Rise takes priority over the timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d = cnt;
          duty_d   = hcnt;
          valid_d  = 1'b1;
        end else if (cnt == TIMEOUT_CYCLES) begin
          state_d  = STUCK;
          period_d = '0;
          duty_d   = '0;
        end
      end
      STUCK: begin
        if (rise) begin
          state_d = MEAS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign PERIOD  = period_q;
  assign DUTY    = duty_q;
  assign VALID   = valid_q;
  assign TIMEOUT = (state_q == STUCK);
  assign LEVEL   = s;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: self-checking bench for pwm_capture.
// Drives PWM waveforms period by period, records every VALID the DUT produces
// and compares against a period-level model of what should be reported.
// Honours PWM_CAPTURE_FILTER_EN (extra latency, minimum pulse width, glitch test).
module tb_pwm_capture;

  localparam int W  = 28;
  localparam int T  = 64;
  localparam int FL = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int LAT  = 3 + FL;
  localparam int MINP = FL;
`else
  localparam int LAT  = 3;
  localparam int MINP = 1;
`endif

  logic         CLK;
  logic         RST;
  logic         PWM_IN;
  logic [W-1:0] PERIOD;
  logic [W-1:0] DUTY;
  logic         VALID;
  logic         TIMEOUT;
  logic         LEVEL;

  int pass_cnt;
  int total_cnt;
  int cyc;

  logic [W-1:0] smp_period;
  logic [W-1:0] smp_duty;
  logic         smp_timeout;
  logic         smp_level;

  int obs_p[$];
  int obs_d[$];
  int obs_c[$];
  int per_q[$];
  int dut_q[$];
  int rise_q[$];
  int exp_p[$];
  int exp_d[$];
  int exp_c[$];

  pwm_capture #(
    .WIDTH         (W),
    .TIMEOUT_CYCLES(W'(T)),
    .FILTER_LEN    (FL)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .PWM_IN (PWM_IN),
    .PERIOD (PERIOD),
    .DUTY   (DUTY),
    .VALID  (VALID),
    .TIMEOUT(TIMEOUT),
    .LEVEL  (LEVEL)
  );

  // Free-running 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One bench cycle: sample outputs on the falling edge, log any VALID, then
  // apply the next input level for the following rising edge.
  task automatic step(input logic v);
    @(negedge CLK);
    cyc++;
    smp_period  = PERIOD;
    smp_duty    = DUTY;
    smp_timeout = TIMEOUT;
    smp_level   = LEVEL;
    if (VALID === 1'b1) begin
      obs_p.push_back(int'(PERIOD));
      obs_d.push_back(int'(DUTY));
      obs_c.push_back(cyc);
    end
    PWM_IN = v;
  endtask

  // One generator period: high for d cycles, then low for p-d cycles.
  task automatic drive_period(input int p, input int d);
    step(1'b1);
    rise_q.push_back(cyc);
    per_q.push_back(p);
    dut_q.push_back(d);
    for (int i = 1; i < p; i++) step(i < d);
  endtask

  task automatic tail();
    for (int i = 0; i < LAT + 2; i++) step(1'b0);
  endtask

  task automatic clear_queues();
    obs_p.delete(); obs_d.delete(); obs_c.delete();
    per_q.delete(); dut_q.delete(); rise_q.delete();
    exp_p.delete(); exp_d.delete(); exp_c.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST    = 1'b1;
    PWM_IN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    clear_queues();
  endtask

  // Period-level model: every rise after the first closes the previous period;
  // that period is reported LAT cycles after the rise unless it was longer than
  // the timeout (the input went stuck and the partial period is dropped).
  task automatic build_expected();
    exp_p.delete(); exp_d.delete(); exp_c.delete();
    for (int i = 1; i < per_q.size(); i++) begin
      if (per_q[i-1] <= T) begin
        exp_p.push_back(per_q[i-1]);
        exp_d.push_back(dut_q[i-1]);
        exp_c.push_back(rise_q[i] + LAT);
      end
    end
  endtask

  // Outputs are all zero while reset is held, even after real measurements.
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 3; k++) drive_period(10, 3);
    tail();
    total_cnt++;
    if (smp_period !== W'(10)) $display("[TB] FAIL reset_pre_period: got %0d, want 10", smp_period);
    else pass_cnt++;
    @(negedge CLK);
    RST    = 1'b1;
    PWM_IN = 1'b1;
    #1;
    total_cnt++;
    if (PERIOD !== '0) $display("[TB] FAIL reset_period: got %0d, want 0", PERIOD); else pass_cnt++;
    total_cnt++;
    if (DUTY !== '0) $display("[TB] FAIL reset_duty: got %0d, want 0", DUTY); else pass_cnt++;
    total_cnt++;
    if (VALID !== 1'b0) $display("[TB] FAIL reset_valid: got %b, want 0", VALID); else pass_cnt++;
    total_cnt++;
    if (TIMEOUT !== 1'b0) $display("[TB] FAIL reset_timeout: got %b, want 0", TIMEOUT); else pass_cnt++;
    total_cnt++;
    if (LEVEL !== 1'b0) $display("[TB] FAIL reset_level: got %b, want 0", LEVEL); else pass_cnt++;
    @(negedge CLK);
    PWM_IN = 1'b0;
    RST    = 1'b0;
  endtask

  // P=10, D=3 stream: nothing on the first rise, then 10/3 on every rise.
  task automatic test_basic();
    do_reset();
    for (int k = 0; k < 6; k++) drive_period(10, 3);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL basic_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL basic_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

  // Duty changes from 3 to 7 mid-stream with no corrupt value in between.
  task automatic test_duty_change();
    do_reset();
    for (int k = 0; k < 4; k++) drive_period(10, 3);
    for (int k = 0; k < 4; k++) drive_period(10, 7);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL duty_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL duty_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

  // Periods of exactly the timeout are reported; one cycle longer goes stuck
  // and is dropped, and the period after leaving the stuck state is reported.
  task automatic test_period_boundary();
    do_reset();
    drive_period(10, 3);
    drive_period(T, 5);
    drive_period(T + 1, 5);
    drive_period(10, 3);
    drive_period(10, 3);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL boundary_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL boundary_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

  // Random periods and duties, occasionally longer than the timeout.
  task automatic test_random();
    int p;
    int d;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (k == 6) p = T + 1 + int'($urandom_range(10, 0));
      else        p = int'($urandom_range(50, 2 * MINP));
      d = int'($urandom_range(p - MINP, MINP));
      drive_period(p, d);
    end
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL random_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL random_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

  // Input held low after a rise: timeout exactly T cycles after the rise is
  // registered, results cleared, then recovery on the next high.
  task automatic test_timeout_low();
    int k;
    int h;
    do_reset();
    drive_period(10, 3);
    drive_period(10, 3);
    step(1'b1);
    k = cyc;
    step(1'b1);
    step(1'b1);
    while (cyc < k + LAT + T - 1) step(1'b0);
    total_cnt++;
    if (smp_timeout !== 1'b0 || smp_period !== W'(10))
      $display("[TB] FAIL stuck_low_early: got TIMEOUT=%b PERIOD=%0d, want TIMEOUT=0 PERIOD=10", smp_timeout, smp_period);
    else pass_cnt++;
    step(1'b0);
    total_cnt++;
    if (smp_timeout !== 1'b1)
      $display("[TB] FAIL stuck_low_timeout: got %b, want 1", smp_timeout);
    else pass_cnt++;
    total_cnt++;
    if (smp_period !== '0 || smp_duty !== '0 || smp_level !== 1'b0)
      $display("[TB] FAIL stuck_low_values: got P=%0d D=%0d LEVEL=%b, want P=0 D=0 LEVEL=0", smp_period, smp_duty, smp_level);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) step(1'b0);
    clear_queues();
    step(1'b1);
    h = cyc;
    rise_q.push_back(h);
    per_q.push_back(10);
    dut_q.push_back(3);
    for (int i = 1; i < 10; i++) begin
      step(i < 3);
      if (cyc == h + LAT - 1) begin
        total_cnt++;
        if (smp_timeout !== 1'b1) $display("[TB] FAIL stuck_exit_hold: got TIMEOUT=%b, want 1", smp_timeout);
        else pass_cnt++;
      end
      if (cyc == h + LAT) begin
        total_cnt++;
        if (smp_timeout !== 1'b0) $display("[TB] FAIL stuck_exit_clear: got TIMEOUT=%b, want 0", smp_timeout);
        else pass_cnt++;
      end
    end
    drive_period(10, 3);
    drive_period(10, 3);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL recover_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL recover_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

  // Input held high from reset: one rise, then timeout with LEVEL=1.
  task automatic test_timeout_high();
    int k;
    do_reset();
    step(1'b1);
    k = cyc;
    while (cyc < k + LAT + T - 1) step(1'b1);
    total_cnt++;
    if (smp_timeout !== 1'b0) $display("[TB] FAIL stuck_high_early: got TIMEOUT=%b, want 0", smp_timeout);
    else pass_cnt++;
    step(1'b1);
    total_cnt++;
    if (smp_timeout !== 1'b1 || smp_level !== 1'b1)
      $display("[TB] FAIL stuck_high: got TIMEOUT=%b LEVEL=%b, want TIMEOUT=1 LEVEL=1", smp_timeout, smp_level);
    else pass_cnt++;
    total_cnt++;
    if (obs_c.size() !== 0) $display("[TB] FAIL stuck_high_novalid: got %0d VALIDs, want 0", obs_c.size());
    else pass_cnt++;
  endtask

  // One-cycle reset in the low phase: outputs cleared, partial count dropped,
  // first VALID on the second rise afterwards.
  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 3; k++) drive_period(10, 3);
    for (int i = 0; i < 6; i++) step(i < 3);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total_cnt++;
    if (PERIOD !== '0 || DUTY !== '0 || VALID !== 1'b0 || TIMEOUT !== 1'b0 || LEVEL !== 1'b0)
      $display("[TB] FAIL midreset_outputs: got P=%0d D=%0d V=%b T=%b L=%b, want all 0", PERIOD, DUTY, VALID, TIMEOUT, LEVEL);
    else pass_cnt++;
    @(negedge CLK);
    RST = 1'b0;
    clear_queues();
    for (int k = 0; k < 3; k++) drive_period(10, 3);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL midreset_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL midreset_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask

`ifdef PWM_CAPTURE_FILTER_EN
  // A 2-cycle glitch inside the low phase is filtered out; 20/8 reads back.
  task automatic test_filter();
    do_reset();
    drive_period(20, 8);
    drive_period(20, 8);
    step(1'b1);
    rise_q.push_back(cyc);
    per_q.push_back(20);
    dut_q.push_back(8);
    for (int i = 1; i < 20; i++) step((i < 8) || (i >= 12 && i < 14));
    drive_period(20, 8);
    drive_period(20, 8);
    tail();
    build_expected();
    total_cnt++;
    if (obs_c.size() !== exp_c.size())
      $display("[TB] FAIL filter_count: got %0d VALIDs, want %0d", obs_c.size(), exp_c.size());
    else pass_cnt++;
    for (int j = 0; j < exp_c.size() && j < obs_c.size(); j++) begin
      total_cnt++;
      if (obs_p[j] !== exp_p[j] || obs_d[j] !== exp_d[j] || obs_c[j] !== exp_c[j])
        $display("[TB] FAIL filter_valid[%0d]: got P=%0d D=%0d cyc=%0d, want P=%0d D=%0d cyc=%0d",
                 j, obs_p[j], obs_d[j], obs_c[j], exp_p[j], exp_d[j], exp_c[j]);
      else pass_cnt++;
    end
  endtask
`endif

  // Test sequence.
  initial begin
    RST       = 1'b0;
    PWM_IN    = 1'b0;
    cyc       = 0;
    pass_cnt  = 0;
    total_cnt = 0;
    $display("[TB] start, latency %0d, timeout %0d", LAT, T);
    test_reset();
    test_basic();
    test_duty_change();
    test_period_boundary();
    test_random();
    test_timeout_low();
    test_timeout_high();
    test_mid_reset();
`ifdef PWM_CAPTURE_FILTER_EN
    test_filter();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
